// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL dynamic reconfiguration controller.
//   state_e    : controller states
//   div_cfg_t  : one set of PLL divider selects (IDSEL / FBDSEL / ODSEL)
//   DIV_W      : width of each divider select
//   GATE_CYCLES: clock-gating hold time before a PLL reset
//   cnt_w()    : counter width for a cycle count, never below one bit
package pll_ctrl_pkg;

  localparam int DIV_W       = 6;
  localparam int GATE_CYCLES = 2;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    RUN,
    GATE,
    FAULT
  } state_e;

  typedef struct packed {
    logic [DIV_W-1:0] idsel;
    logic [DIV_W-1:0] fbdsel;
    logic [DIV_W-1:0] odsel;
  } div_cfg_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic reconfiguration controller: sequences PLL reset, waits for a
// stable lock, gates downstream clocks and applies new divider selects.
//   clk, rst_n                   : system clock, async active-low reset
//   cfg_req, cfg_*sel            : reconfiguration request and divider selects
//   cfg_ack, cfg_busy            : acceptance pulse, busy indication
//   pll_lock                     : raw PLL lock (asynchronous)
//   pll_reset, pll_*sel          : PLL reset and divider select drive
//   clk_en, locked, err          : downstream enable, lock status, retry fault
module pll_dyn_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int               RST_CYCLES   = 16,
  parameter int               LOCK_STABLE  = 1024,
  parameter int               LOCK_TIMEOUT = 65535,
  parameter int               MAX_RETRY    = 3,
  parameter logic [DIV_W-1:0] DEF_IDSEL    = '0,
  parameter logic [DIV_W-1:0] DEF_FBDSEL   = '0,
  parameter logic [DIV_W-1:0] DEF_ODSEL    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_idsel,
  input  logic [DIV_W-1:0] cfg_fbdsel,
  input  logic [DIV_W-1:0] cfg_odsel,
  output logic             cfg_ack,
  output logic             cfg_busy,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [DIV_W-1:0] pll_idsel,
  output logic [DIV_W-1:0] pll_fbdsel,
  output logic [DIV_W-1:0] pll_odsel,
  output logic             clk_en,
  output logic             locked,
  output logic             err
);

  localparam int RST_W = cnt_w(RST_CYCLES);
  localparam int STB_W = cnt_w(LOCK_STABLE);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT);
  // The retry counter has to hold the value MAX_RETRY itself.
  localparam int RTY_W = cnt_w(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [RST_W-1:0] GATE_LAST = RST_W'(GATE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam div_cfg_t         DEF_CFG   = '{DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};

  logic lock_s;

  state_e             state_q, state_d;
  logic [RST_W-1:0]   phase_cnt_q, phase_cnt_d;   // shared by RESET and GATE
  logic [STB_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [TMO_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  div_cfg_t           shadow_q, shadow_d;
  div_cfg_t           div_q, div_d;
  logic               cfg_ack_q, cfg_ack_d;
  logic               locked_q, locked_d;
  logic               accept;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET;
      phase_cnt_q   <= '0;
      stable_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      retry_q       <= '0;
      shadow_q      <= DEF_CFG;
      div_q         <= DEF_CFG;
      cfg_ack_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      retry_q       <= retry_d;
      shadow_q      <= shadow_d;
      div_q         <= div_d;
      cfg_ack_q     <= cfg_ack_d;
      locked_q      <= locked_d;
    end
  end

  // Next-state logic. Lock completion is checked before timeout so it wins,
  // and cfg_req is checked before lock loss in RUN so it wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:     if (phase_cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s && (stable_cnt_q == STB_LAST)) begin
          state_d = RUN;
        end else if (timeout_cnt_q == TMO_LAST) begin
          state_d = (retry_q < RTY_MAX) ? RESET : FAULT;
        end
      end
      RUN: begin
        if (cfg_req)      state_d = GATE;
        else if (!lock_s) state_d = WAIT_LOCK;
      end
      GATE:      if (phase_cnt_q == GATE_LAST) state_d = RESET;
      FAULT:     if (cfg_req) state_d = GATE;
      default:   state_d = RESET;
    endcase
  end

  // Counters, shadow capture and divider update.
  always_comb begin
    phase_cnt_d   = phase_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    retry_d       = retry_q;
    shadow_d      = shadow_q;
    div_d         = div_q;
    cfg_ack_d     = 1'b0;
    accept        = cfg_req && ((state_q == RUN) || (state_q == FAULT));

    // Every counter restarts from zero on any state change; all saturate.
    if (state_d != state_q) begin
      phase_cnt_d   = '0;
      stable_cnt_d  = '0;
      timeout_cnt_d = '0;
    end else begin
      if ((state_q == RESET) || (state_q == GATE)) begin
        if (phase_cnt_q != '1) phase_cnt_d = phase_cnt_q + 1'b1;
      end
      if (state_q == WAIT_LOCK) begin
        if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 1'b1;
        if (!lock_s)                   stable_cnt_d = '0;
        else if (stable_cnt_q != '1)   stable_cnt_d = stable_cnt_q + 1'b1;
      end
    end

    if (accept) begin
      shadow_d  = '{cfg_idsel, cfg_fbdsel, cfg_odsel};
      cfg_ack_d = 1'b1;
      retry_d   = '0;
    end else if ((state_q == WAIT_LOCK) && (state_d == RESET)) begin
      if (retry_q != '1) retry_d = retry_q + 1'b1;
    end

    // Load on the edge entering RESET so new selects are visible on its
    // first cycle and frozen everywhere else.
    if ((state_d == RESET) && (state_q != RESET)) div_d = shadow_q;

    // Asserted one cycle after entering RUN; dropped with the exit edge.
    locked_d = (state_q == RUN) && (state_d == RUN);
  end

  // Outputs.
  always_comb begin
    pll_reset  = (state_q == RESET) || (state_q == FAULT);
    cfg_busy   = (state_q != RUN) && (state_q != FAULT);
    err        = (state_q == FAULT);
    cfg_ack    = cfg_ack_q;
    locked     = locked_q;
    clk_en     = locked_q;
    pll_idsel  = div_q.idsel;
    pll_fbdsel = div_q.fbdsel;
    pll_odsel  = div_q.odsel;
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
module tb_pll_dyn_ctrl;

  localparam logic [5:0] DEF_ID = 6'd1;
  localparam logic [5:0] DEF_FB = 6'd2;
  localparam logic [5:0] DEF_OD = 6'd3;
  localparam logic [17:0] DEF_DIV = {DEF_ID, DEF_FB, DEF_OD};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_req = 1'b0;
  logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
  logic       pll_lock = 1'b0;
  logic       cfg_ack, cfg_busy, pll_reset, clk_en, locked, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

  pll_dyn_ctrl #(
    .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2),
    .DEF_IDSEL(DEF_ID), .DEF_FBDSEL(DEF_FB), .DEF_ODSEL(DEF_OD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .clk_en(clk_en), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_ACK, EV_ERR_SET, EV_ERR_CLR, EV_UNLOCK, EV_LOCK, EV_RST_START, EV_RST_END} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          at;
    logic [17:0] div;
    int          width;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic expect_ev(input ev_kind_e k, input int at, input logic [17:0] d, input int w);
    ev_t e;
    e.kind = k; e.at = at; e.div = d; e.width = w;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_e k, input logic [17:0] d, input int w);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got kind=%s cyc=%0d div=%h width=%0d required none", k.name(), cyc, d, w);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc || e.div != d || e.width != w) begin
        bad++;
        $display("FAIL event got kind=%s cyc=%0d div=%h width=%0d required kind=%s cyc=%0d div=%h width=%0d",
                 k.name(), cyc, d, w, e.kind.name(), e.at, e.div, e.width);
      end else begin
        $display("event ok kind=%s cyc=%0d div=%h width=%0d", k.name(), cyc, d, w);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check ok %s value=%0h", name, act);
    end
  endtask

  // Monitor: turns output edges into events and scores them against the queue.
  logic prev_rst = 1'b1, prev_lock = 1'b0, prev_err = 1'b0;
  int   width = 0;
  always @(negedge clk) begin
    logic [17:0] div;
    div = {pll_idsel, pll_fbdsel, pll_odsel};
    if (!rst_n) begin
      width = 0;
    end else begin
      if (cfg_ack)              got(EV_ACK, '0, 0);
      if (err && !prev_err)     got(EV_ERR_SET, '0, 0);
      if (!err && prev_err)     got(EV_ERR_CLR, '0, 0);
      if (!locked && prev_lock) got(EV_UNLOCK, '0, int'(clk_en));
      if (locked && !prev_lock) got(EV_LOCK, '0, int'(clk_en));
      if (pll_reset && !prev_rst) begin
        width = 1;
        got(EV_RST_START, div, 0);
      end else if (pll_reset) begin
        width++;
      end
      if (!pll_reset && prev_rst) begin
        got(EV_RST_END, div, width);
        width = 0;
      end
    end
    prev_rst  = pll_reset;
    prev_lock = locked;
    prev_err  = err;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
    cfg_req = 1'b1; cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od;
  endtask

  initial begin
    int c;
    int r;
    int d;

    // Reset state.
    step(3);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_ack", 32'({err, cfg_ack}), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd1);
    chk("rst_dividers", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(DEF_DIV));

    // Power-up: 4-cycle reset pulse, lock raised 10 cycles after release.
    c = cyc;
    rst_n = 1'b1;
    expect_ev(EV_RST_END, c + 4, DEF_DIV, 4);
    step(10);
    pll_lock = 1'b1;
    expect_ev(EV_LOCK, c + 21, '0, 1);
    step(15);
    chk("run_busy", 32'(cfg_busy), 32'd0);
    chk("run_clk_en", 32'(clk_en), 32'd1);

    // Reconfiguration from RUN.
    c = cyc;
    expect_ev(EV_ACK, c + 1, '0, 0);
    expect_ev(EV_UNLOCK, c + 1, '0, 0);
    expect_ev(EV_RST_START, c + 3, {6'd1, 6'd7, 6'd4}, 0);
    expect_ev(EV_RST_END, c + 7, {6'd1, 6'd7, 6'd4}, 4);
    expect_ev(EV_LOCK, c + 16, '0, 1);
    send_cfg(6'd1, 6'd7, 6'd4);
    step(1);
    cfg_req = 1'b0; cfg_fbdsel = 6'd63; cfg_odsel = 6'd63;
    step(1);
    chk("gate_div_hold", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(DEF_DIV));
    chk("gate_no_reset", 32'(pll_reset), 32'd0);
    step(19);

    // Lock loss in RUN, ignored cfg_req in WAIT_LOCK, then a glitchy relock.
    c = cyc;
    pll_lock = 1'b0;
    expect_ev(EV_UNLOCK, c + 3, '0, 0);
    step(3);
    send_cfg(6'd9, 6'd9, 6'd9);
    step(2);
    cfg_req = 1'b0;
    step(1);
    chk("wait_div_unchanged", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'd1, 6'd7, 6'd4}));
    chk("wait_busy", 32'(cfg_busy), 32'd1);
    r = cyc;
    pll_lock = 1'b1;
    expect_ev(EV_LOCK, r + 17, '0, 1);
    step(5);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(15);

    // Mid-sequence reset during WAIT_LOCK after a cfg_req.
    c = cyc;
    expect_ev(EV_ACK, c + 1, '0, 0);
    expect_ev(EV_UNLOCK, c + 1, '0, 0);
    expect_ev(EV_RST_START, c + 3, {6'd13, 6'd11, 6'd12}, 0);
    expect_ev(EV_RST_END, c + 7, {6'd13, 6'd11, 6'd12}, 4);
    send_cfg(6'd13, 6'd11, 6'd12);
    step(1);
    cfg_req = 1'b0;
    pll_lock = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(1);
    chk("midrst_dividers", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(DEF_DIV));
    chk("midrst_pll_reset", 32'(pll_reset), 32'd1);
    chk("midrst_busy", 32'(cfg_busy), 32'd1);

    // Restarted power-up with no lock: initial pulse + 2 retries, then FAULT.
    d = cyc;
    rst_n = 1'b1;
    expect_ev(EV_RST_END, d + 4, DEF_DIV, 4);
    expect_ev(EV_RST_START, d + 36, DEF_DIV, 0);
    expect_ev(EV_RST_END, d + 40, DEF_DIV, 4);
    expect_ev(EV_RST_START, d + 72, DEF_DIV, 0);
    expect_ev(EV_RST_END, d + 76, DEF_DIV, 4);
    expect_ev(EV_ERR_SET, d + 108, '0, 0);
    expect_ev(EV_RST_START, d + 108, DEF_DIV, 0);
    step(110);
    chk("fault_err", 32'(err), 32'd1);
    chk("fault_pll_reset", 32'(pll_reset), 32'd1);
    chk("fault_clk_en", 32'(clk_en), 32'd0);
    chk("fault_busy", 32'(cfg_busy), 32'd0);

    // cfg_req out of FAULT clears err and restarts the sequence.
    expect_ev(EV_ACK, d + 111, '0, 0);
    expect_ev(EV_ERR_CLR, d + 111, '0, 0);
    expect_ev(EV_RST_END, d + 111, DEF_DIV, 3);
    expect_ev(EV_RST_START, d + 113, {6'd2, 6'd3, 6'd4}, 0);
    expect_ev(EV_RST_END, d + 117, {6'd2, 6'd3, 6'd4}, 4);
    expect_ev(EV_LOCK, d + 126, '0, 1);
    send_cfg(6'd2, 6'd3, 6'd4);
    step(1);
    cfg_req = 1'b0;
    step(2);
    pll_lock = 1'b1;
    step(20);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events actual_left=%0d required_left=0 next_kind=%s next_cyc=%0d",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
